imem_ahb_ctrl: RTL and testbench

- Instruction-memory responder for the fetch stage in configurations without an ITCM.
- Accepts the fetch stage's `next_pc` every cycle and fetches the word over an AHB-lite master port, one transfer outstanding at a time.
- Returns `instr_read_data`/`instr_read_data_valid` aligned to the fetch stage's current `pc`.
- Silently drops responses made stale by redirects (branch, jal/jalr, trap, mret, dret).

---
 rtl/imem_ahb_ctrl_pkg.sv | 24 ++
 rtl/en_cnt.sv | 29 ++
 rtl/imem_ahb_ctrl.sv | 152 +++++++++++++++
 tb/tb_imem_ahb_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_ahb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : imem_ahb_ctrl_pkg
// Desc   : AHB-lite constants and fetch-controller state encodings.
// Rev    : 1.0
// ============================================================================
package imem_ahb_ctrl_pkg;

  localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] c_HSIZE_WORD    = 3'b010;
  localparam logic [2:0] c_HBURST_SINGLE = 3'b000;
  localparam logic [3:0] c_HPROT_OPCODE  = 4'b0010;

  // Shared with the data-memory AHB master.
  localparam logic [1:0] c_ST_ADDR = 2'd0;
  localparam logic [1:0] c_ST_DATA = 2'd1;
  localparam logic [1:0] c_ST_RESP = 2'd2;
  localparam logic [1:0] c_ST_ERR  = 2'd3;

  localparam int unsigned c_STALE_CNT_WIDTH = 16;

endpackage
`default_nettype wire

// File: rtl/en_cnt.sv
`default_nettype none
// ============================================================================
// Module : en_cnt
// Desc   : Free-running event counter, increments when en is high.
// Rev    : 1.0
// ============================================================================
module en_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/imem_ahb_ctrl.sv
`default_nettype none
// ============================================================================
// Module : imem_ahb_ctrl
// Desc   : Fetch-stage instruction responder over an AHB-lite master port.
// Rev    : 1.0
// ============================================================================
module imem_ahb_ctrl
  import imem_ahb_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                         cpu_clk,
  input  logic                         cpu_rst,
  input  logic [ADDR_WIDTH-1:0]        boot_addr,
  input  logic [ADDR_WIDTH-1:0]        next_pc,
  output logic                         instr_read_data_valid,
  output logic [INSTR_WIDTH-1:0]       instr_read_data,
  output logic                         instr_bus_err,
  output logic [ADDR_WIDTH-1:0]        haddr,
  output logic [1:0]                   htrans,
  output logic                         hwrite,
  output logic [2:0]                   hsize,
  output logic [2:0]                   hburst,
  output logic [3:0]                   hprot,
  input  logic                         hready,
  input  logic                         hresp,
  input  logic [INSTR_WIDTH-1:0]       hrdata,
  output logic [c_STALE_CNT_WIDTH-1:0] stale_drop_cnt
);

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_cur_pc;
  logic [ADDR_WIDTH-1:0]  r_req_addr;
  logic [ADDR_WIDTH-1:0]  w_req_nxt;
  logic [ADDR_WIDTH-1:0]  r_buf_addr;
  logic [INSTR_WIDTH-1:0] r_buf_data;
  logic                   w_buf_load;
  logic                   w_stale;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_state    <= c_ST_ADDR;
      r_req_addr <= boot_addr;
      r_cur_pc   <= boot_addr;
      r_buf_addr <= '1;
      r_buf_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_req_addr <= w_req_nxt;
      r_cur_pc   <= next_pc;
      if (w_buf_load) begin
        r_buf_addr <= r_req_addr;
        r_buf_data <= hrdata;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req_addr;
    w_buf_load  = 1'b0;
    w_stale     = 1'b0;
    case (r_state)
      c_ST_ADDR: begin
        // Misaligned targets never reach the bus; keep tracking the fetch pc.
        if (r_req_addr[1:0] != 2'b00) begin
          w_req_nxt = next_pc;
        end else if (hready) begin
          w_state_nxt = c_ST_DATA;
        end
      end
      c_ST_DATA: begin
        if (hready) begin
          if (hresp) begin
            w_state_nxt = c_ST_ERR;
          end else begin
            w_buf_load = 1'b1;
            if (r_req_addr == next_pc) begin
              w_state_nxt = c_ST_RESP;
            end else begin
              w_state_nxt = c_ST_ADDR;
              w_req_nxt   = next_pc;
              w_stale     = 1'b1;
            end
          end
        end
      end
      c_ST_RESP: begin
        if (next_pc != r_buf_addr) begin
          w_state_nxt = c_ST_ADDR;
          w_req_nxt   = next_pc;
        end
      end
      c_ST_ERR: begin
        w_state_nxt = c_ST_ADDR;
        w_req_nxt   = next_pc;
      end
      default: begin
        w_state_nxt = c_ST_ADDR;
        w_req_nxt   = next_pc;
      end
    endcase
  end

  always_comb begin
    htrans                = c_HTRANS_IDLE;
    haddr                 = '0;
    instr_read_data_valid = 1'b0;
    instr_read_data       = '0;
    instr_bus_err         = 1'b0;
    if (!cpu_rst) begin
      haddr = r_req_addr;
      case (r_state)
        c_ST_ADDR: begin
          if (r_req_addr[1:0] == 2'b00) begin
            htrans = c_HTRANS_NONSEQ;
          end
        end
        c_ST_RESP: begin
          if (r_buf_addr == r_cur_pc) begin
            instr_read_data_valid = 1'b1;
            instr_read_data       = r_buf_data;
          end
        end
        c_ST_ERR: begin
          instr_read_data_valid = 1'b1;
          instr_bus_err         = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign hwrite = 1'b0;
  assign hsize  = c_HSIZE_WORD;
  assign hburst = c_HBURST_SINGLE;
  assign hprot  = c_HPROT_OPCODE;

  en_cnt #(
    .WIDTH (c_STALE_CNT_WIDTH)
  ) u_stale_cnt (
    .clk   (cpu_clk),
    .rst   (cpu_rst),
    .en    (w_stale),
    .count (stale_drop_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_imem_ahb_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_imem_ahb_ctrl
// Desc   : Self-checking bench for imem_ahb_ctrl with an AHB memory responder.
// Rev    : 1.0
// ============================================================================
module tb_imem_ahb_ctrl;

  logic        cpu_clk   = 1'b0;
  logic        cpu_rst   = 1'b1;
  logic [31:0] boot_addr = 32'h100;
  logic [31:0] next_pc   = 32'h100;
  logic        instr_read_data_valid;
  logic [31:0] instr_read_data;
  logic        instr_bus_err;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hready = 1'b1;
  logic        hresp  = 1'b0;
  logic [31:0] hrdata = 32'h0;
  logic [15:0] stale_drop_cnt;

  int tests = 0;
  int fails = 0;

  always #5 cpu_clk = ~cpu_clk;

  imem_ahb_ctrl #(
    .ADDR_WIDTH  (32),
    .INSTR_WIDTH (32)
  ) dut (
    .cpu_clk               (cpu_clk),
    .cpu_rst               (cpu_rst),
    .boot_addr             (boot_addr),
    .next_pc               (next_pc),
    .instr_read_data_valid (instr_read_data_valid),
    .instr_read_data       (instr_read_data),
    .instr_bus_err         (instr_bus_err),
    .haddr                 (haddr),
    .htrans                (htrans),
    .hwrite                (hwrite),
    .hsize                 (hsize),
    .hburst                (hburst),
    .hprot                 (hprot),
    .hready                (hready),
    .hresp                 (hresp),
    .hrdata                (hrdata),
    .stale_drop_cnt        (stale_drop_cnt)
  );

  // Memory contents and error map of the simulated AHB slave.
  function automatic logic [31:0] mem(input logic [31:0] a);
    mem = (a == 32'h100) ? 32'h0000_0013 : {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  function automatic logic is_err(input logic [31:0] a);
    is_err = (a[11:8] == 4'h3);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'($urandom_range(0, 255)) << 2;
    if ($urandom_range(0, 15) == 0) a = a | 32'h2;
    rand_addr = a;
  endfunction

  // Slave state
  bit          s_pend  = 1'b0;
  logic [31:0] s_addr  = 32'h0;
  int          s_wcnt  = 0;
  int          s_waits = 0;
  bit          s_rand  = 1'b0;

  // Reference model state (transaction level)
  bit          m_out       = 1'b0;
  logic [31:0] m_addr      = 32'h0;
  logic [31:0] pc          = 32'h100;
  bit          m_valid     = 1'b0;
  bit          m_err       = 1'b0;
  logic [31:0] m_data      = 32'h0;
  int          m_stale     = 0;
  bit          m_nswait    = 1'b0;
  logic [31:0] m_hold_addr = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: check outputs against the model, then advance slave and model.
  task automatic cycle();
    bit          acc, mdone, rdy, rst_now, nswait, hold;
    logic [31:0] np, ha;
    #1;
    if (!cpu_rst) begin
      check("mon_valid", 64'(instr_read_data_valid), 64'(m_valid));
      check("mon_bus_err", 64'(instr_bus_err), 64'(m_err));
      check("mon_data", 64'(instr_read_data), 64'(m_valid ? m_data : 32'h0));
      if (instr_read_data_valid) check("mon_idle_when_valid", 64'(htrans), 64'(2'b00));
      if (htrans == 2'b10) begin
        check("mon_aligned", 64'(haddr[1:0]), 64'(2'b00));
        if (!m_nswait) check("mon_new_addr", 64'(haddr), 64'(pc));
      end else begin
        check("mon_htrans_legal", 64'(htrans), 64'(2'b00));
      end
      if (m_nswait) check("mon_addr_hold", 64'({htrans, haddr}), 64'({2'b10, m_hold_addr}));
    end
    rdy     = hready;
    acc     = hready && (htrans == 2'b10);
    nswait  = (htrans == 2'b10) && !hready;
    ha      = haddr;
    np      = next_pc;
    rst_now = cpu_rst;
    @(posedge cpu_clk);
    #1;
    if (s_pend && !rdy) s_wcnt--;
    if (s_pend && rdy) s_pend = 1'b0;
    if (acc) begin
      s_pend = 1'b1;
      s_addr = ha;
      s_wcnt = s_rand ? int'($urandom_range(0, 2)) : s_waits;
    end
    hready = !s_pend || (s_wcnt == 0);
    hresp  = s_pend && (s_wcnt == 0) && is_err(s_addr);
    hrdata = (s_pend && (s_wcnt == 0) && !is_err(s_addr)) ? mem(s_addr) : 32'hDEAD_BEEF;
    if (rst_now) begin
      m_out    = 1'b0;
      m_valid  = 1'b0;
      m_err    = 1'b0;
      m_nswait = 1'b0;
      m_stale  = 0;
      pc       = boot_addr;
    end else begin
      mdone = m_out && rdy;
      if (mdone && !is_err(m_addr) && (m_addr != np)) m_stale++;
      hold    = m_valid && !m_err && (np == pc);
      m_err   = mdone && is_err(m_addr);
      m_valid = (mdone && (is_err(m_addr) || (m_addr == np))) || hold;
      if (mdone) m_data = is_err(m_addr) ? 32'h0 : mem(m_addr);
      if (acc) begin
        m_out  = 1'b1;
        m_addr = ha;
      end else if (mdone) begin
        m_out = 1'b0;
      end
      m_nswait    = nswait;
      m_hold_addr = ha;
      pc          = np;
    end
  endtask

  typedef struct {
    logic        rst;
    logic [31:0] np;
    logic        valid;
    logic [31:0] data;
    logic        err;
    logic [1:0]  htrans;
    logic [31:0] haddr;
  } vec_t;

  vec_t tbl [21];

  initial begin
    int  vcount, ph, since, timeouts, r;
    int  vcyc [3];
    bit  got, saw, bad;

    // Zero-wait directed vectors: reset, first fetch, hold, error, stale, misaligned.
    tbl[0]  = '{1'b1, 32'h100, 1'b0, 32'h0,          1'b0, 2'b00, 32'h0};
    tbl[1]  = '{1'b0, 32'h100, 1'b0, 32'h0,          1'b0, 2'b10, 32'h100};
    tbl[2]  = '{1'b0, 32'h100, 1'b0, 32'h0,          1'b0, 2'b00, 32'h100};
    tbl[3]  = '{1'b0, 32'h100, 1'b1, 32'h0000_0013,  1'b0, 2'b00, 32'h100};
    tbl[4]  = '{1'b0, 32'h100, 1'b1, 32'h0000_0013,  1'b0, 2'b00, 32'h100};
    tbl[5]  = '{1'b0, 32'h300, 1'b1, 32'h0000_0013,  1'b0, 2'b00, 32'h100};
    tbl[6]  = '{1'b0, 32'h300, 1'b0, 32'h0,          1'b0, 2'b10, 32'h300};
    tbl[7]  = '{1'b0, 32'h300, 1'b0, 32'h0,          1'b0, 2'b00, 32'h300};
    tbl[8]  = '{1'b0, 32'h180, 1'b1, 32'h0,          1'b1, 2'b00, 32'h300};
    tbl[9]  = '{1'b0, 32'h180, 1'b0, 32'h0,          1'b0, 2'b10, 32'h180};
    tbl[10] = '{1'b0, 32'h184, 1'b0, 32'h0,          1'b0, 2'b00, 32'h180};
    tbl[11] = '{1'b0, 32'h184, 1'b0, 32'h0,          1'b0, 2'b10, 32'h184};
    tbl[12] = '{1'b0, 32'h184, 1'b0, 32'h0,          1'b0, 2'b00, 32'h184};
    tbl[13] = '{1'b0, 32'h188, 1'b1, mem(32'h184),   1'b0, 2'b00, 32'h184};
    tbl[14] = '{1'b0, 32'h102, 1'b0, 32'h0,          1'b0, 2'b10, 32'h188};
    tbl[15] = '{1'b0, 32'h102, 1'b0, 32'h0,          1'b0, 2'b00, 32'h188};
    tbl[16] = '{1'b0, 32'h102, 1'b0, 32'h0,          1'b0, 2'b00, 32'h102};
    tbl[17] = '{1'b0, 32'h180, 1'b0, 32'h0,          1'b0, 2'b00, 32'h102};
    tbl[18] = '{1'b0, 32'h180, 1'b0, 32'h0,          1'b0, 2'b10, 32'h180};
    tbl[19] = '{1'b0, 32'h180, 1'b0, 32'h0,          1'b0, 2'b00, 32'h180};
    tbl[20] = '{1'b0, 32'h184, 1'b1, mem(32'h180),   1'b0, 2'b00, 32'h180};

    s_waits   = 0;
    s_rand    = 1'b0;
    boot_addr = 32'h100;
    for (int i = 0; i < 21; i++) begin
      cpu_rst = tbl[i].rst;
      next_pc = tbl[i].np;
      #1;
      check($sformatf("vec%0d_valid", i),  64'(instr_read_data_valid), 64'(tbl[i].valid));
      check($sformatf("vec%0d_data", i),   64'(instr_read_data),       64'(tbl[i].data));
      check($sformatf("vec%0d_err", i),    64'(instr_bus_err),         64'(tbl[i].err));
      check($sformatf("vec%0d_htrans", i), 64'(htrans),                64'(tbl[i].htrans));
      check($sformatf("vec%0d_haddr", i),  64'(haddr),                 64'(tbl[i].haddr));
      cycle();
    end
    check("vec_stale_cnt", 64'(stale_drop_cnt), 64'(2));
    check("hwrite", 64'(hwrite), 64'(1'b0));
    check("hsize",  64'(hsize),  64'(3'b010));
    check("hburst", 64'(hburst), 64'(3'b000));
    check("hprot",  64'(hprot),  64'(4'b0010));

    // Sequential fetch with two wait states per data phase.
    s_waits = 2;
    cpu_rst = 1'b1; boot_addr = 32'h100; next_pc = 32'h100;
    cycle();
    cpu_rst = 1'b0;
    vcount  = 0;
    for (int c = 0; c < 40 && vcount < 3; c++) begin
      #1;
      if (instr_read_data_valid) begin
        vcyc[vcount] = c;
        vcount++;
        check("seq_data", 64'(instr_read_data), 64'(mem(pc)));
        next_pc = pc + 32'd4;
      end else begin
        next_pc = pc;
      end
      cycle();
    end
    check("seq_count", 64'(vcount), 64'(3));
    if (vcount == 3) begin
      check("seq_first_latency", 64'(vcyc[0]), 64'(4));
      check("seq_gap1", 64'(vcyc[1] - vcyc[0]), 64'(5));
      check("seq_gap2", 64'(vcyc[2] - vcyc[1]), 64'(5));
    end

    // Redirect to 0x200 during the data phase of 0x104.
    cpu_rst = 1'b1; next_pc = 32'h100;
    cycle();
    cpu_rst = 1'b0;
    ph = 0; got = 1'b0; saw = 1'b0; bad = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      #1;
      if (htrans == 2'b10 && haddr == 32'h200) saw = 1'b1;
      if (instr_read_data_valid && pc == 32'h104) bad = 1'b1;
      if (instr_read_data_valid && pc == 32'h200) begin
        got = 1'b1;
        check("redir_data", 64'(instr_read_data), 64'(mem(32'h200)));
      end
      if (ph == 0 && instr_read_data_valid) begin
        next_pc = 32'h104;
        ph = 1;
      end else if (ph == 1 && htrans == 2'b10 && haddr == 32'h104) begin
        ph = 2;
      end else if (ph == 2) begin
        next_pc = 32'h200;
        ph = 3;
      end
      cycle();
    end
    check("redir_got_200", 64'(got), 64'(1));
    check("redir_saw_nonseq_200", 64'(saw), 64'(1));
    check("redir_no_104_valid", 64'(bad), 64'(0));
    check("redir_stale_cnt", 64'(stale_drop_cnt), 64'(1));

    // Reset asserted while a data phase is still in flight.
    cpu_rst = 1'b1; boot_addr = 32'h100; next_pc = 32'h100;
    cycle();
    cpu_rst = 1'b0;
    #1;
    check("rstmid_nonseq_100", 64'({htrans, haddr}), 64'({2'b10, 32'h100}));
    cycle();
    cpu_rst = 1'b1; boot_addr = 32'h240; next_pc = 32'h240;
    #1;
    check("rstmid_rst_htrans", 64'(htrans), 64'(2'b00));
    check("rstmid_rst_haddr", 64'(haddr), 64'(32'h0));
    check("rstmid_rst_valid", 64'(instr_read_data_valid), 64'(0));
    cycle();
    cpu_rst = 1'b0;
    #1;
    check("rstmid_post_nonseq", 64'({htrans, haddr}), 64'({2'b10, 32'h240}));
    cycle();
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (instr_read_data_valid) begin
        got = 1'b1;
        check("rstmid_data", 64'(instr_read_data), 64'(mem(32'h240)));
      end
      cycle();
    end
    check("rstmid_got", 64'(got), 64'(1));

    // Randomized fetch stream with random wait states, redirects and resets.
    s_rand  = 1'b1;
    cpu_rst = 1'b1; boot_addr = 32'h100; next_pc = 32'h100;
    cycle();
    cpu_rst  = 1'b0;
    since    = 0;
    timeouts = 0;
    for (int c = 0; c < 3000; c++) begin
      #1;
      if ($urandom_range(0, 499) == 0) begin
        cpu_rst   = 1'b1;
        boot_addr = rand_addr() & 32'hFFFF_FFFC;
        next_pc   = boot_addr;
        since     = 0;
      end else begin
        cpu_rst = 1'b0;
        r = int'($urandom_range(0, 99));
        if (pc[1:0] != 2'b00) next_pc = 32'h180;
        else if (instr_read_data_valid)
          next_pc = (r < 20) ? pc : (r < 75) ? ((pc + 32'd4) & 32'h3FF) : rand_addr();
        else
          next_pc = (r < 8) ? rand_addr() : pc;
        if (instr_read_data_valid || next_pc != pc) since = 0;
        else since++;
        if (since == 20) timeouts++;
      end
      cycle();
    end
    cpu_rst = 1'b0;
    check("rand_timeouts", 64'(timeouts), 64'(0));
    check("rand_stale_cnt", 64'(stale_drop_cnt), 64'(m_stale));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=time_limit required=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
